score_keeper: RTL and testbench

//  Match scorekeeper for 16x16 Connect Four; directly upstream of the HEX score display.

---
 rtl/score_pkg.sv | 18 +
 rtl/edge_pulse.sv | 22 ++
 rtl/score_keeper.sv | 143 ++++++++++++++
 tb/tb_score_keeper.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the Connect Four match scorekeeper.
// Holds the FSM state encoding, the score width and the counter-width helper.
package score_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    HOLD       = 2'd1,
    MATCH_OVER = 2'd2
  } state_t;

  localparam int SCORE_W = 3;

  // The counter is shared by the board hold and the auto-restart interval (4x hold).
  function automatic int cnt_width(input int hold_cycles);
    return $clog2(4 * hold_cycles + 1);
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// One-bit rising-edge detector: registers the previous level and flags low->high.
// The previous-level flop updates every cycle regardless of what the consumer is doing.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/score_keeper.sv
// Match scorekeeper: turns win levels into saturating green/red scores, holds decided boards,
// and freezes at match end. Define AUTO_NEWMATCH_EN to let MATCH_OVER restart on its own.
//
// Handshake note: there is no valid/ready pair here; newGame is a one-cycle strobe that is
// acted on in the cycle it is sampled, and boardClear is a one-cycle command with no ack.
module score_keeper
  import score_pkg::*;
#(
  parameter int WIN_SCORE   = 5,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               winG,
  input  logic               winR,
  input  logic               newGame,
  output logic [SCORE_W-1:0] scoreG,
  output logic [SCORE_W-1:0] scoreR,
  output logic               roundOver,
  output logic               matchOver,
  output logic               boardClear,
  output state_t             state_dbg
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
`ifdef AUTO_NEWMATCH_EN
  localparam logic [CNT_W-1:0]   AUTO_LAST = CNT_W'(4 * HOLD_CYCLES - 1);
`endif

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   next_cnt;
  logic [SCORE_W-1:0] next_score_g;
  logic [SCORE_W-1:0] next_score_r;
  logic [SCORE_W-1:0] inc_g;
  logic [SCORE_W-1:0] inc_r;
  logic               next_clear;
  logic               rise_g;
  logic               rise_r;

  edge_pulse u_edge_g (
    .clk   (clk),
    .rst   (RST),
    .level (winG),
    .rise  (rise_g)
  );

  edge_pulse u_edge_r (
    .clk   (clk),
    .rst   (RST),
    .level (winR),
    .rise  (rise_r)
  );

  assign inc_g     = scoreG + SCORE_ONE;
  assign inc_r     = scoreR + SCORE_ONE;
  assign state_dbg = state;

  always_comb begin
    next_state   = state;
    next_cnt     = cnt;
    next_score_g = scoreG;
    next_score_r = scoreR;
    next_clear   = 1'b0;
    if (newGame) begin
      // Restart outranks every other event this cycle, including a fresh win or terminal count.
      next_state   = PLAY;
      next_cnt     = '0;
      next_score_g = '0;
      next_score_r = '0;
      next_clear   = 1'b1;
    end else begin
      case (state)
        PLAY: begin
          next_cnt = '0;
          if (rise_g && rise_r) begin
            next_state = HOLD;
          end else if (rise_g) begin
            next_score_g = inc_g;
            next_state   = (inc_g == WIN_VAL) ? MATCH_OVER : HOLD;
          end else if (rise_r) begin
            next_score_r = inc_r;
            next_state   = (inc_r == WIN_VAL) ? MATCH_OVER : HOLD;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            next_cnt   = '0;
            next_clear = 1'b1;
            next_state = PLAY;
          end else begin
            next_cnt = cnt + CNT_W'(1);
          end
        end
        MATCH_OVER: begin
`ifdef AUTO_NEWMATCH_EN
          if (cnt == AUTO_LAST) begin
            next_state   = PLAY;
            next_cnt     = '0;
            next_score_g = '0;
            next_score_r = '0;
            next_clear   = 1'b1;
          end else begin
            next_cnt = cnt + CNT_W'(1);
          end
`else
          next_cnt = '0;
`endif
        end
        default: begin
          next_state = PLAY;
          next_cnt   = '0;
        end
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state      <= PLAY;
      cnt        <= '0;
      scoreG     <= '0;
      scoreR     <= '0;
      roundOver  <= 1'b0;
      matchOver  <= 1'b0;
      boardClear <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      scoreG     <= next_score_g;
      scoreR     <= next_score_r;
      roundOver  <= (next_state == HOLD);
      matchOver  <= (next_state == MATCH_OVER);
      boardClear <= next_clear;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper with HOLD_CYCLES=4, WIN_SCORE=5: directed vectors push timed output
// events into a queue; a negedge monitor pops one entry whenever the output vector changes.
module tb_score_keeper;
  import score_pkg::*;

  localparam int EW = 25;  // {cycle[15:0], boardClear, matchOver, roundOver, scoreG, scoreR}

  logic       clk;
  logic       RST;
  logic       winG;
  logic       winR;
  logic       newGame;
  logic [2:0] scoreG;
  logic [2:0] scoreR;
  logic       roundOver;
  logic       matchOver;
  logic       boardClear;
  state_t     state_dbg;

  logic [EW-1:0] exp_q[$];
  logic [8:0]    prev_out;
  logic          mon_en;
  int            cyc;
  int            total;
  int            bad;
  int            t;

  score_keeper #(
    .WIN_SCORE   (5),
    .HOLD_CYCLES (4)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .winG       (winG),
    .winR       (winR),
    .newGame    (newGame),
    .scoreG     (scoreG),
    .scoreR     (scoreR),
    .roundOver  (roundOver),
    .matchOver  (matchOver),
    .boardClear (boardClear),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int at, input logic bc, input logic mo, input logic ro,
                           input int sg, input int sr);
    exp_q.push_back({16'(at), bc, mo, ro, 3'(sg), 3'(sr)});
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [8:0]    cur;
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    cur = {boardClear, matchOver, roundOver, scoreG, scoreR};
    if (mon_en && cur !== prev_out) begin
      total++;
      got = {16'(cyc), cur};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change: cyc=%0d bc/mo/ro=%b sg=%0d sr=%0d", cyc,
                 cur[8:6], cur[5:3], cur[2:0]);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL event: got cyc=%0d bc/mo/ro=%b sg=%0d sr=%0d, want cyc=%0d bc/mo/ro=%b sg=%0d sr=%0d",
                   got[24:9], got[8:6], got[5:3], got[2:0], e[24:9], e[8:6], e[5:3], e[2:0]);
        end
      end
    end
    prev_out = cur;
  end

  initial begin
    total    = 0;
    bad      = 0;
    mon_en   = 1'b0;
    prev_out = '0;
    RST      = 1'b1;
    winG     = 1'b0;
    winR     = 1'b0;
    newGame  = 1'b0;
    tick(2);
    chk("reset_outputs", 32'({boardClear, matchOver, roundOver, scoreG, scoreR}), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'(PLAY));
    RST    = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // green win held 3 cycles: one increment, 4-cycle hold, single clear pulse
    t = cyc; winG = 1'b1;
    expect_ev(t + 1, 0, 0, 1, 1, 0);
    expect_ev(t + 5, 1, 0, 0, 1, 0);
    expect_ev(t + 6, 0, 0, 0, 1, 0);
    tick(3); winG = 1'b0; tick(6);

    // simultaneous rise: draw
    t = cyc; winG = 1'b1; winR = 1'b1;
    expect_ev(t + 1, 0, 0, 1, 1, 0);
    expect_ev(t + 5, 1, 0, 0, 1, 0);
    expect_ev(t + 6, 0, 0, 0, 1, 0);
    tick(2); winG = 1'b0; winR = 1'b0; tick(6);

    // red level stays high past the hold: only one increment
    t = cyc; winR = 1'b1;
    expect_ev(t + 1, 0, 0, 1, 1, 1);
    expect_ev(t + 5, 1, 0, 0, 1, 1);
    expect_ev(t + 6, 0, 0, 0, 1, 1);
    tick(10); winR = 1'b0; tick(3);

    // red wins 2..4
    for (int n = 2; n <= 4; n++) begin
      t = cyc; winR = 1'b1;
      expect_ev(t + 1, 0, 0, 1, 1, n);
      expect_ev(t + 5, 1, 0, 0, 1, n);
      expect_ev(t + 6, 0, 0, 0, 1, n);
      tick(1); winR = 1'b0; tick(7);
    end

    // fifth red win ends the match; later rises are ignored
    t = cyc; winR = 1'b1;
    expect_ev(t + 1, 0, 1, 0, 1, 5);
    tick(1); winR = 1'b0; tick(2);
    winG = 1'b1; tick(1); winG = 1'b0;
    winR = 1'b1; tick(1); winR = 1'b0;
`ifdef AUTO_NEWMATCH_EN
    expect_ev(t + 17, 1, 0, 0, 0, 0);
    expect_ev(t + 18, 0, 0, 0, 0, 0);
    tick(20);
`else
    tick(100);
    chk("match_frozen_scoreR", 32'(scoreR), 32'd5);
    t = cyc; newGame = 1'b1;
    expect_ev(t + 1, 1, 0, 0, 0, 0);
    expect_ev(t + 2, 0, 0, 0, 0, 0);
    tick(1); newGame = 1'b0; tick(3);
`endif

    // newGame beats a simultaneous red rise in PLAY
    t = cyc; newGame = 1'b1; winR = 1'b1;
    expect_ev(t + 1, 1, 0, 0, 0, 0);
    expect_ev(t + 2, 0, 0, 0, 0, 0);
    tick(1); newGame = 1'b0; tick(3); winR = 1'b0; tick(2);

    // newGame mid-hold cuts the hold short
    t = cyc; winG = 1'b1;
    expect_ev(t + 1, 0, 0, 1, 1, 0);
    expect_ev(t + 3, 1, 0, 0, 0, 0);
    expect_ev(t + 4, 0, 0, 0, 0, 0);
    tick(1); winG = 1'b0; tick(1); newGame = 1'b1; tick(1); newGame = 1'b0; tick(4);

    // asynchronous reset mid-hold clears outputs before the next edge
    t = cyc; winR = 1'b1;
    expect_ev(t + 1, 0, 0, 1, 0, 1);
    tick(2);
    #2;
    mon_en = 1'b0;
    RST    = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({boardClear, matchOver, roundOver, scoreG, scoreR}), 32'd0);
    chk("async_reset_state", 32'(state_dbg), 32'(PLAY));
    winR = 1'b0;
    tick(1);
    RST = 1'b0;
    tick(1);
    mon_en = 1'b1;
    tick(3);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    while (exp_q.size() != 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event: want cyc=%0d bc/mo/ro=%b sg=%0d sr=%0d, got none",
               e[24:9], e[8:6], e[5:3], e[2:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
